// File: rtl/divider_request_sequencer.sv
// Host/consumer wrapper around the divider controller: one operation in flight, four-phase Req/Done.
// Best case is 4 cycles from accept to OutValid; a stalled consumer holds the result and blocks new operands.
module divider_request_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] OpDividend,
  output logic [WIDTH-1:0] OpDivisor,
  output logic             Req,
  input  logic             Done,
  input  logic [WIDTH-1:0] QuotientIn,
  input  logic [WIDTH-1:0] RemainderIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RELEASE, RESULT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      InReady    <= 1'b1;
      Req        <= 1'b0;
      OutValid   <= 1'b0;
      OpDividend <= '0;
      OpDivisor  <= '0;
      Quotient   <= '0;
      Remainder  <= '0;
      DivByZero  <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            InReady   <= 1'b0;
            DivByZero <= 1'b0;
            Timeout   <= 1'b0;
            if (Divisor != '0) begin
              OpDividend <= Dividend;
              OpDivisor  <= Divisor;
              Req        <= 1'b1;
              state      <= ISSUE;
            end else begin
              // Zero divisor is answered locally; the controller never sees it.
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
              OutValid  <= 1'b1;
              state     <= RESULT;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Done is checked first so a completion on the last allowed cycle is kept.
          if (Done) begin
            Quotient  <= QuotientIn;
            Remainder <= RemainderIn;
            Req       <= 1'b0;
            state     <= WAIT_RELEASE;
          end else if (cnt == CNT_LAST) begin
            Quotient  <= '0;
            Remainder <= '0;
            Timeout   <= 1'b1;
            Req       <= 1'b0;
            state     <= WAIT_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!Done) begin
            OutValid <= 1'b1;
            state    <= RESULT;
          end
        end
        RESULT: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          Req      <= 1'b0;
          OutValid <= 1'b0;
          InReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_request_sequencer.sv
// Bench for divider_request_sequencer: directed scenarios plus randomized operations,
// with the external divider controller and expected results modelled arithmetically.
module tb_divider_request_sequencer;

  localparam int W  = 16;
  localparam int TO = 40;

  logic         Clock = 1'b0;
  logic         Reset, InValid, InReady, Req, Done, OutValid, OutReady, DivByZero, Timeout;
  logic [W-1:0] Dividend, Divisor, OpDividend, OpDivisor, QuotientIn, RemainderIn, Quotient, Remainder;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  divider_request_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Dividend(Dividend), .Divisor(Divisor), .OpDividend(OpDividend), .OpDivisor(OpDivisor),
    .Req(Req), .Done(Done), .QuotientIn(QuotientIn), .RemainderIn(RemainderIn),
    .OutValid(OutValid), .OutReady(OutReady), .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero), .Timeout(Timeout)
  );

  // One complete operation: host offer, controller model, consumer with optional stall.
  // dly: cycles after Req first seen before Done rises; hold: extra cycles Done stays high after Req drops.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int dly,
                        input int hold, input int stall, input bit respond);
    logic [W-1:0] eq, er;
    logic         edz, eto;
    int           req_hi, n, en;
    if (b == '0) begin
      eq = '1; er = a; edz = 1'b1; eto = 1'b0;
    end else if (!respond) begin
      eq = '0; er = '0; edz = 1'b0; eto = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; eto = 1'b0;
    end
    en = (b == '0) ? 0 : 1;

    @(negedge Clock);
    checks++;
    if (InReady !== 1'b1) begin
      errors++; $display("FAIL in_ready_idle got=%b exp=1", InReady);
    end
    InValid = 1'b1; Dividend = a; Divisor = b;
    @(negedge Clock);
    InValid = 1'b0; Dividend = W'($urandom); Divisor = W'($urandom);
    checks++;
    if (InReady !== 1'b0) begin
      errors++; $display("FAIL in_ready_busy got=%b exp=0", InReady);
    end

    if (b == '0) begin
      checks++;
      if (Req !== 1'b0 || OutValid !== 1'b1) begin
        errors++; $display("FAIL dz_immediate req=%b ov=%b exp req=0 ov=1", Req, OutValid);
      end
    end else begin
      checks++;
      if (Req !== 1'b1 || OpDividend !== a || OpDivisor !== b || DivByZero !== 1'b0 || Timeout !== 1'b0) begin
        errors++;
        $display("FAIL issue req=%b opa=%h opb=%h dz=%b to=%b exp req=1 opa=%h opb=%h dz=0 to=0",
                 Req, OpDividend, OpDivisor, DivByZero, Timeout, a, b);
      end
      req_hi = 1;
      if (respond) begin
        for (int i = 0; i < dly; i++) begin
          @(negedge Clock);
          if (Req === 1'b1) req_hi++;
        end
        Done = 1'b1;
        QuotientIn  = OpDividend / OpDivisor;
        RemainderIn = OpDividend % OpDivisor;
        @(negedge Clock);
        checks++;
        if (Req !== 1'b0 || req_hi != dly + 1) begin
          errors++; $display("FAIL req_drop req=%b req_cycles=%0d exp req=0 req_cycles=%0d", Req, req_hi, dly + 1);
        end
        for (int i = 0; i < hold; i++) begin
          @(negedge Clock);
          checks++;
          if (Req !== 1'b0 || OutValid !== 1'b0) begin
            errors++; $display("FAIL release_hold req=%b ov=%b exp req=0 ov=0", Req, OutValid);
          end
        end
        Done = 1'b0;
        QuotientIn = W'($urandom); RemainderIn = W'($urandom);
      end else begin
        while (Req === 1'b1 && req_hi < 4 * TO) begin
          @(negedge Clock);
          if (Req === 1'b1) req_hi++;
        end
        // ISSUE cycle plus TO counted waiting cycles.
        checks++;
        if (req_hi != TO + 1) begin
          errors++; $display("FAIL timeout_len req_cycles=%0d exp=%0d", req_hi, TO + 1);
        end
      end
    end

    n = 0;
    while (OutValid !== 1'b1 && n < 8) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (OutValid !== 1'b1 || n != en) begin
      errors++; $display("FAIL out_valid ov=%b wait=%0d exp ov=1 wait=%0d", OutValid, n, en);
    end
    checks++;
    if (Quotient !== eq || Remainder !== er || DivByZero !== edz || Timeout !== eto) begin
      errors++;
      $display("FAIL result q=%h r=%h dz=%b to=%b exp q=%h r=%h dz=%b to=%b",
               Quotient, Remainder, DivByZero, Timeout, eq, er, edz, eto);
    end
    for (int i = 0; i < stall; i++) begin
      InValid = 1'b1; Dividend = W'($urandom); Divisor = W'($urandom);
      @(negedge Clock);
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Req !== 1'b0 || Quotient !== eq ||
          Remainder !== er || DivByZero !== edz || Timeout !== eto) begin
        errors++;
        $display("FAIL stall_hold ov=%b ir=%b req=%b q=%h r=%h exp ov=1 ir=0 req=0 q=%h r=%h",
                 OutValid, InReady, Req, Quotient, Remainder, eq, er);
      end
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++; $display("FAIL out_release ov=%b ir=%b exp ov=0 ir=1", OutValid, InReady);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (InReady !== 1'b1 || Req !== 1'b0 || OutValid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl ir=%b req=%b ov=%b exp ir=1 req=0 ov=0", InReady, Req, OutValid);
    end
    checks++;
    if (Quotient !== '0 || Remainder !== '0 || OpDividend !== '0 || OpDivisor !== '0 ||
        DivByZero !== 1'b0 || Timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data q=%h r=%h opa=%h opb=%h dz=%b to=%b exp all 0",
               Quotient, Remainder, OpDividend, OpDivisor, DivByZero, Timeout);
    end
    Reset = 1'b0;
  endtask

  task automatic test_normal();
    run_op(16'd100, 16'd7, 18, 0, 0, 1'b1);
  endtask

  task automatic test_div_zero();
    run_op(16'h1234, 16'h0000, 0, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_op(16'd1000, 16'd33, 3, 1, 10, 1'b1);
  endtask

  task automatic test_timeout();
    run_op(16'd500, 16'd3, 0, 0, 0, 1'b0);
    // Done on the final allowed cycle still counts as a normal completion.
    run_op(16'd60000, 16'd7, TO, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    InValid = 1'b1; Dividend = 16'd77; Divisor = 16'd3;
    @(negedge Clock);
    InValid = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL mid_req req=%b exp=1", Req);
    end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checks++;
    if (Req !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b1 || OpDividend !== '0 || OpDivisor !== '0) begin
      errors++;
      $display("FAIL mid_reset req=%b ov=%b ir=%b opa=%h opb=%h exp req=0 ov=0 ir=1 opa=0 opb=0",
               Req, OutValid, InReady, OpDividend, OpDivisor);
    end
    Done = 1'b1; QuotientIn = W'($urandom); RemainderIn = W'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      checks++;
      if (Req !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b1) begin
        errors++; $display("FAIL done_in_idle req=%b ov=%b ir=%b exp req=0 ov=0 ir=1", Req, OutValid, InReady);
      end
    end
    Done = 1'b0;
    @(negedge Clock);
    run_op(16'd50, 16'd5, 4, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op(16'd9,   16'd2,  1, 1, 0, 1'b1);
    run_op(16'd255, 16'd16, 1, 1, 0, 1'b1);
    run_op(16'd1,   16'd1,  1, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 300));
        default: b = W'($urandom_range(1, 65535));
      endcase
      run_op(a, b, $urandom_range(1, TO), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 7) != 0));
    end
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; Dividend = '0; Divisor = '0;
    Done = 1'b0; QuotientIn = '0; RemainderIn = '0; OutReady = 1'b0;
    test_reset();
    test_normal();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_request_sequencer.md
Name: divider_request_sequencer

Overview:
Upstream/downstream wrapper around the divider control block and bitslice datapath.
- Accepts operand pairs from the host over a valid/ready handshake.
- Holds operands stable and drives the controller's Req using a four-phase Req/Done handshake.
- Captures quotient and remainder when Done rises, then presents them to the consumer over a valid/ready handshake.
- Handles divide-by-zero locally, and aborts with an error if the controller never answers.

Parameters:
WIDTH, 16, operand/result bit width of the bitslice datapath
TIMEOUT, 40, max cycles Req may stay high without Done before abort (must be >= WIDTH+2)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
InValid  input  1  host offers an operand pair
InReady  output  1  sequencer can accept an operand pair
Dividend  input  WIDTH  host dividend, sampled on InValid&&InReady
Divisor  input  WIDTH  host divisor, sampled on InValid&&InReady
OpDividend  output  WIDTH  registered dividend to datapath, stable while Req=1
OpDivisor  output  WIDTH  registered divisor to datapath, stable while Req=1
Req  output  1  request to divider controller
Done  input  1  completion from divider controller
QuotientIn  input  WIDTH  quotient from datapath, valid when Done=1
RemainderIn  input  WIDTH  remainder from datapath, valid when Done=1
OutValid  output  1  result available
OutReady  input  1  consumer accepts result
Quotient  output  WIDTH  captured quotient
Remainder  output  WIDTH  captured remainder
DivByZero  output  1  result flag: divisor was zero
Timeout  output  1  result flag: controller did not answer in time

Behaviour:
- Reset (synchronous, checked on every edge, overrides everything, including mid-operation):
  - state=IDLE; Req=0, OutValid=0, InReady=1.
  - Quotient, Remainder, OpDividend, OpDivisor all 0; DivByZero=0, Timeout=0; timeout counter=0.
  - Reset asserted while Req=1 drops Req on the next edge; a Done arriving afterwards is ignored while in IDLE.
- Each state registers its own outputs (no combinational paths from inputs to outputs). States:
- IDLE: InReady=1.
  - On InValid=1 with Divisor!=0: latch operands into OpDividend/OpDivisor, go to ISSUE.
  - On InValid=1 with Divisor==0: Quotient={WIDTH{1}}, Remainder=Dividend, DivByZero=1, Timeout=0, go to RESULT. Req is never raised.
- ISSUE: Req=1, InReady=0, counter cleared. Next cycle goes to WAIT_DONE. Req is first high the cycle after acceptance.
- WAIT_DONE: Req=1, counter increments each cycle.
  - Done=1 sampled: capture QuotientIn/RemainderIn, DivByZero=0, Timeout=0, Req<=0, go to WAIT_RELEASE.
  - Counter reaches TIMEOUT with Done=0: Req<=0, Quotient=0, Remainder=0, Timeout=1, go to WAIT_RELEASE.
  - Done and timeout in the same cycle: Done wins (normal capture).
- WAIT_RELEASE: Req=0.
  - Wait for Done=0 sampled, then go to RESULT.
  - Entered via timeout with Done already 0: leave after one cycle.
- RESULT: OutValid=1, outputs held stable, InReady=0.
  - On OutReady=1: OutValid<=0, go to IDLE.
  - Consumer may hold OutReady low indefinitely; no new operand is accepted meanwhile.
- Throughput: one operation in flight, no pipelining. Minimum cycles from acceptance to OutValid, with Done returning one cycle after Req: 4.
- Done observed in IDLE, ISSUE or RESULT is a protocol error and is ignored.
- Flags are mutually exclusive; both are cleared when the next operation is accepted.

Test Plan:
- Normal op: Dividend=100, Divisor=7; model returns Done 18 cycles after Req with Q=14, R=2 -> Req drops the cycle after Done is sampled; OutValid=1 with Quotient=14, Remainder=2, flags 0.
- Divide by zero: Dividend=0x1234, Divisor=0 -> Req never rises; OutValid the next cycle with Quotient=0xFFFF, Remainder=0x1234, DivByZero=1.
- Backpressure: OutReady=0 for 10 cycles after OutValid -> outputs stable and InReady=0 throughout; OutReady=1 -> OutValid=0 and InReady=1 next cycle.
- Timeout: Done tied 0 -> Req high for exactly TIMEOUT (40) counted cycles, then drops; OutValid with Quotient=0, Remainder=0, Timeout=1.
- Reset mid-operation: assert Reset while Req=1, then pulse Done -> Req=0 after the reset edge, Done ignored, OutValid stays 0; a fresh op 50/5 then returns Q=10, R=0.
- Back-to-back: three ops (9/2, 255/16, 1/1) with OutReady=1 and Done held high 2 cycles each -> results 4r1, 15r15, 1r0 in order; Req never rises while Done is still high.
